// File: rtl/sha256_block_sequencer.sv
// sha256_block_sequencer
// Drives a programmable sequence of 512-bit blocks into a SHA-256 core under a
// busy/comp_done handshake. It captures the digest from the last block and
// compares it against a fixed expected value. The result is reported as
// pass, fail or timeout.
module sha256_block_sequencer #(
    parameter int unsigned  NUM_BLOCKS     = 2,
    parameter int unsigned  PATTERN_MODE   = 1,
    parameter logic [255:0] EXPECTED_HASH  = 256'h0,
    parameter bit           CHECK_EN       = 1'b1,
    parameter int unsigned  TIMEOUT_CYCLES = 1024,
    parameter bit           AUTO_RESTART   = 1'b0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         run,
    output logic         core_start_block,
    output logic         core_block_valid,
    output logic [511:0] core_block_in,
    input  logic         core_busy,
    input  logic [255:0] core_hash_out,
    input  logic         core_comp_done,
    output logic         seq_busy,
    output logic         seq_done,
    output logic         pass,
    output logic         fail,
    output logic         timeout,
    output logic [7:0]   blocks_sent,
    output logic [255:0] hash_result
);

    // The padded "abc" message always fits in one block, so the block count
    // collapses to 1 in that mode whatever NUM_BLOCKS says.
    localparam int unsigned EFF_BLOCKS = (PATTERN_MODE == 2) ? 1 : NUM_BLOCKS;
    localparam logic [7:0]  LAST_IDX   = 8'(EFF_BLOCKS - 1);

    // The timer only ever needs to reach TIMEOUT_CYCLES-1.
    localparam int unsigned TW        = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TIMER_MAX = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT_DONE,
        S_CHECK,
        S_DONE
    } state_t;

    state_t          state_reg;
    logic [7:0]      blk_idx_reg;
    logic [TW-1:0]   timer_reg;
    logic [511:0]    pattern_next;
    logic            timer_expired;
    logic            digest_ok;
    logic            restart_go;

    // Build the block for the current index, one 32-bit word per generate lane.
    // Word 0 sits in the most significant bits of the block.
    for (genvar gi = 0; gi < 16; gi++) begin : g_word
        localparam logic [31:0] ABC_WORD = (gi == 0)  ? 32'h6162_6380 :
                                           (gi == 15) ? 32'h0000_0018 :
                                                        32'h0000_0000;
        logic [31:0] cnt_word;

        // 16*k + i is simply the block index concatenated with the word index.
        assign cnt_word = {20'd0, blk_idx_reg, 4'(gi)};

        assign pattern_next[511-32*gi -: 32] = (PATTERN_MODE == 1) ? cnt_word :
                                               (PATTERN_MODE == 2) ? ABC_WORD :
                                                                     32'h0000_0000;
    end

    assign timer_expired = (timer_reg == TIMER_MAX);
    assign digest_ok     = (hash_result == EXPECTED_HASH) || !CHECK_EN;

    // A new run starts on an explicit request, or automatically one cycle
    // after DONE when auto-restart is enabled.
    assign restart_go = run || ((state_reg == S_DONE) && AUTO_RESTART);

    // Sequencer FSM with all outputs registered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg        <= S_IDLE;
            blk_idx_reg      <= 8'd0;
            timer_reg        <= '0;
            core_start_block <= 1'b0;
            core_block_valid <= 1'b0;
            core_block_in    <= '0;
            seq_busy         <= 1'b0;
            seq_done         <= 1'b0;
            pass             <= 1'b0;
            fail             <= 1'b0;
            timeout          <= 1'b0;
            blocks_sent      <= 8'd0;
            hash_result      <= '0;
        end else begin
            // The valid and start outputs are single-cycle pulses by default.
            core_block_valid <= 1'b0;
            core_start_block <= 1'b0;

            case (state_reg)
                S_IDLE, S_DONE: begin
                    if (restart_go) begin
                        state_reg   <= S_ISSUE;
                        seq_busy    <= 1'b1;
                        seq_done    <= 1'b0;
                        pass        <= 1'b0;
                        timeout     <= 1'b0;
                        blocks_sent <= 8'd0;
                        blk_idx_reg <= 8'd0;
                        timer_reg   <= '0;
                        // Only an explicit run clears fail, so an automatic
                        // loop keeps any earlier failure visible.
                        if (run) begin
                            fail <= 1'b0;
                        end
                    end
                end

                S_ISSUE: begin
                    if (!core_busy) begin
                        core_block_valid <= 1'b1;
                        core_start_block <= (blk_idx_reg == 8'd0);
                        core_block_in    <= pattern_next;
                        timer_reg        <= '0;
                        state_reg        <= S_WAIT_DONE;
                    end else if (timer_expired) begin
                        timeout   <= 1'b1;
                        fail      <= 1'b1;
                        pass      <= 1'b0;
                        seq_busy  <= 1'b0;
                        seq_done  <= 1'b1;
                        state_reg <= S_DONE;
                    end else begin
                        timer_reg <= timer_reg + TW'(1);
                    end
                end

                S_WAIT_DONE: begin
                    // A completion takes priority over a timer expiring in the
                    // same cycle.
                    if (core_comp_done) begin
                        blocks_sent <= blocks_sent + 8'd1;
                        blk_idx_reg <= blk_idx_reg + 8'd1;
                        timer_reg   <= '0;
                        if (blk_idx_reg == LAST_IDX) begin
                            hash_result <= core_hash_out;
                            state_reg   <= S_CHECK;
                        end else begin
                            state_reg   <= S_ISSUE;
                        end
                    end else if (timer_expired) begin
                        timeout   <= 1'b1;
                        fail      <= 1'b1;
                        pass      <= 1'b0;
                        seq_busy  <= 1'b0;
                        seq_done  <= 1'b1;
                        state_reg <= S_DONE;
                    end else begin
                        timer_reg <= timer_reg + TW'(1);
                    end
                end

                S_CHECK: begin
                    pass      <= digest_ok;
                    fail      <= fail | ~digest_ok;
                    seq_busy  <= 1'b0;
                    seq_done  <= 1'b1;
                    state_reg <= S_DONE;
                end

                default: begin
                    state_reg <= S_IDLE;
                    seq_busy  <= 1'b0;
                    seq_done  <= 1'b0;
                end
            endcase
        end
    end

endmodule
